// File: rtl/hazard_pkg.sv
// hazard_pkg: shared register-address width, address type and forward-select encodings
package hazard_pkg;
  localparam int DEF_REG_ADDR_W = 5;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef logic [DEF_REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/long_op_tracker.sv
// long_op_tracker: latency counter and per-register pending bits for the single long-latency unit
module long_op_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue,
  input  logic [REG_ADDR_W-1:0]    issue_rd,
  input  logic [LAT_W-1:0]         issue_lat,
  output logic [2**REG_ADDR_W-1:0] pending,
  output logic                     busy,
  output logic                     lu_wb_valid,
  output logic [REG_ADDR_W-1:0]    lu_wb_rd
);
  logic [LAT_W-1:0]      cnt;
  logic [REG_ADDR_W-1:0] lu_rd;
  assign lu_wb_valid = busy && cnt == LAT_W'(1);
  assign lu_wb_rd = lu_rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      busy <= 1'b0;
      cnt <= '0;
      lu_rd <= '0;
    end else begin
      if (lu_wb_valid) begin
        busy <= 1'b0;
        pending[lu_rd] <= 1'b0;
      end else if (busy) cnt <= cnt - LAT_W'(1);
      // issue comes last so a same-register set beats the retire clear
      if (issue) begin
        busy <= 1'b1;
        cnt <= issue_lat == '0 ? LAT_W'(1) : issue_lat;
        lu_rd <= issue_rd;
        if (issue_rd != '0) pending[issue_rd] <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding, load-use and scoreboard stalls, branch flushes for the 5-stage RV32 pipeline
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MAX_LAT = 34,
  localparam int LAT_W = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  decode_valid,
  input  logic [REG_ADDR_W-1:0] decode_rs_1,
  input  logic [REG_ADDR_W-1:0] decode_rs_2,
  input  logic [REG_ADDR_W-1:0] decode_rd,
  input  logic                  decode_long,
  input  logic [LAT_W-1:0]      decode_long_lat,
  input  logic                  execute_pc_src,
  input  logic                  execute_result_src_0,
  input  logic [REG_ADDR_W-1:0] execute_rs_1,
  input  logic [REG_ADDR_W-1:0] execute_rs_2,
  input  logic [REG_ADDR_W-1:0] execute_rd,
  input  logic [REG_ADDR_W-1:0] memory_rd,
  input  logic [REG_ADDR_W-1:0] writeback_rd,
  input  logic                  memory_reg_write,
  input  logic                  writeback_reg_write,
  output logic                  fetch_stall,
  output logic                  decode_stall,
  output logic                  decode_flush,
  output logic                  execute_flush,
  output logic [1:0]            execute_forward_a,
  output logic [1:0]            execute_forward_b,
  output logic                  lu_wb_valid,
  output logic [REG_ADDR_W-1:0] lu_wb_rd,
  output logic                  lu_busy
);
  logic [2**REG_ADDR_W-1:0] pending;
  logic busy, wb_valid, lw_stall, sb_stall, stall, issue;
  function automatic logic [1:0] fwd(input logic [REG_ADDR_W-1:0] rs, mrd, wrd, input logic mwe, wwe);
    return rs == '0 ? FWD_REG : (mwe && rs == mrd) ? FWD_MEM : (wwe && rs == wrd) ? FWD_WB : FWD_REG;
  endfunction
  always_comb begin
    lw_stall = execute_result_src_0 && execute_rd != '0 &&
               (decode_rs_1 == execute_rd || decode_rs_2 == execute_rd);
    sb_stall = decode_valid && ((pending[decode_rs_1] && decode_rs_1 != '0) ||
               (pending[decode_rs_2] && decode_rs_2 != '0) ||
               (pending[decode_rd] && decode_rd != '0) || (decode_long && busy));
    stall = lw_stall || sb_stall;
    issue = !rst && decode_valid && decode_long && !stall && !execute_pc_src;
  end
  long_op_tracker #(.REG_ADDR_W(REG_ADDR_W), .LAT_W(LAT_W)) u_trk (
    .clk(clk), .rst(rst), .issue(issue), .issue_rd(decode_rd), .issue_lat(decode_long_lat),
    .pending(pending), .busy(busy), .lu_wb_valid(wb_valid), .lu_wb_rd(lu_wb_rd)
  );
  // reset overrides every control output so the pipeline sees bubbles only
  assign fetch_stall = !rst && stall;
  assign decode_stall = !rst && stall;
  assign decode_flush = rst || execute_pc_src;
  assign execute_flush = rst || stall || execute_pc_src;
  assign execute_forward_a = rst ? FWD_REG : fwd(execute_rs_1, memory_rd, writeback_rd, memory_reg_write, writeback_reg_write);
  assign execute_forward_b = rst ? FWD_REG : fwd(execute_rs_2, memory_rd, writeback_rd, memory_reg_write, writeback_reg_write);
  assign lu_wb_valid = !rst && wb_valid;
  assign lu_busy = !rst && busy;
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the 5-stage RV32 pipeline.
- Keeps the existing forwarding, load-use stall and branch-flush behaviour, with x0-safe comparisons on every path.
- Adds a per-register pending scoreboard and a latency counter for one non-pipelined long-latency unit (mul/div) that writes back after N cycles.
- Sits beside the pipeline registers; drives the fetch/decode stall lines, the decode/execute flush lines, the ALU operand-forward muxes and the long-unit writeback strobe.

Parameters:
- REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W.
- MAX_LAT, 34, maximum long-op latency in cycles.
- LAT_W, $clog2(MAX_LAT+1), width of the latency count. Derived localparam, not overridable.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- decode_valid  in  1  a valid instruction is in decode.
- decode_rs_1, decode_rs_2, decode_rd  in  REG_ADDR_W  decode-stage register addresses.
- decode_long  in  1  the decode instruction is a long-unit op.
- decode_long_lat  in  LAT_W  latency of that op, 1..MAX_LAT.
- execute_pc_src  in  1  branch/jump taken in execute.
- execute_result_src_0  in  1  the instruction in execute is a load.
- execute_rs_1, execute_rs_2, execute_rd  in  REG_ADDR_W  execute-stage register addresses.
- memory_rd, writeback_rd  in  REG_ADDR_W  destination registers in memory and writeback.
- memory_reg_write, writeback_reg_write  in  1  write enables in memory and writeback.
- fetch_stall, decode_stall  out  1  hold the PC / hold the IF/ID register.
- decode_flush, execute_flush  out  1  bubble the IF/ID / ID/EX register.
- execute_forward_a, execute_forward_b  out  2  00 regfile, 01 writeback, 10 memory.
- lu_wb_valid  out  1  the long-unit result is written to the regfile this cycle.
- lu_wb_rd  out  REG_ADDR_W  destination of that write.
- lu_busy  out  1  a long op is in flight.

Behaviour:
- Reset: clears pending[NUM_REGS-1:0], busy, cnt and lu_rd.
  - While rst is high, outputs are combinationally forced: fetch_stall=0, decode_stall=0, decode_flush=1, execute_flush=1, forwards=00, lu_wb_valid=0, lu_busy=0.
  - A long op in flight when rst is asserted is discarded; it produces no lu_wb_valid.
- Forwarding (combinational), same rule for a/b:
  - 10 if rs==memory_rd, memory_reg_write=1 and rs!=0.
  - Otherwise 01 if rs==writeback_rd, writeback_reg_write=1 and rs!=0.
  - Otherwise 00. Memory has priority over writeback.
- lw_stall = execute_result_src_0 & execute_rd!=0 & (decode_rs_1==execute_rd | decode_rs_2==execute_rd).
- sb_stall = decode_valid & (src_hit | waw_hit | struct_hit), where:
  - src_hit = pending[rs] for rs_1 or rs_2, rs!=0.
  - waw_hit = pending[decode_rd] & decode_rd!=0.
  - struct_hit = decode_long & busy.
- stall = lw_stall | sb_stall. fetch_stall = decode_stall = stall.
- decode_flush = execute_pc_src. execute_flush = stall | execute_pc_src.
- issue = decode_valid & decode_long & !stall & !execute_pc_src. A flushed op is never issued, so no cancel path exists.
- On issue:
  - busy <= 1; cnt <= decode_long_lat; lu_rd <= decode_rd.
  - pending[decode_rd] <= 1, unless decode_rd == 0.
- While busy, cnt decrements each cycle.
  - lu_wb_valid = busy & cnt==1, with lu_wb_rd = lu_rd.
  - On that edge: busy <= 0 and pending[lu_rd] <= 0.
- Latency: an op issued on edge T has lu_wb_valid high in cycle T+lat (the cycle after edge T+lat-1). Consumers stay stalled through the lu_wb_valid cycle and release the following cycle, reading the regfile directly.
- Same-edge retire and issue: the unit retires as busy clears.
  - struct_hit uses the registered busy, so a new long op stalls one more cycle; back-to-back throughput is lat+1.
  - If issue and retire target the same register on one edge, the set wins.
- decode_long_lat of 0 is illegal. Bench asserts it never occurs; RTL treats it as 1.
- lu_busy = busy.

Decomposition:
- Shared package hazard_pkg:
  - REG_ADDR_W default and the forward-select encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 (shared with the datapath muxes).
  - Typedef reg_addr_t.
- One sub-module, long_op_tracker: owns busy, cnt, lu_rd and pending; outputs pending and lu_wb_*.
- Forwarding, stall and flush logic stays in the top.

Test Plan:
- Forwarding: memory_rd=5, memory_reg_write=1, writeback_rd=5, writeback_reg_write=1, execute_rs_1=5 -> forward_a=10. Same with execute_rs_1=0 -> 00.
- Load-use: execute_result_src_0=1, execute_rd=7, decode_rs_2=7 -> stalls=1, execute_flush=1 for exactly one cycle. Same with execute_rd=0 -> no stall.
- Long op: issue with rd=9, lat=4, then decode reads x9 ->
  - decode_stall through the lu_wb_valid cycle (lu_wb_rd=9, 4 cycles after issue);
  - released the next cycle; pending[9] clear.
- Structural: second long op while busy -> stalled until retire plus one cycle; issues with busy back to 1.
- Branch: execute_pc_src=1 with a long op in decode -> no issue, lu_busy stays 0, decode_flush=1, execute_flush=1.
- Reset mid-op: rst asserted with cnt=3 -> all outputs at reset values; after release no lu_wb_valid and pending is all zero.
